// File: rtl/jedro_1_ifu_prefetch_pkg.sv
// Shared definitions for the jedro_1 instruction fetch unit.
//   INSTR_BYTES   : bytes per instruction word (fetch PC stride)
//   XLEN          : width of the fetch entry fields
//   fetch_entry_t : one buffered instruction together with its PC
//   align_word()  : clears the byte-offset bits of an address
package jedro_1_defines;

  localparam int INSTR_BYTES = 4;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] addr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/jedro_1_ifu_prefetch_if.sv
// Bus bundle of the prefetch stage: redirect input, ROM port and decoder
// handshake. Signal names carry the direction seen from the fetch unit.
//   master : the fetch unit (drives mem_*_o and dec_*_o)
//   slave  : execute stage / ROM / decoder side
interface jedro_1_ifu_prefetch_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  jmp_valid_i;
  logic [ADDR_WIDTH-1:0] jmp_addr_i;
  logic                  mem_en_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [DATA_WIDTH-1:0] mem_rdata_i;
  logic                  dec_valid_o;
  logic                  dec_ready_i;
  logic [DATA_WIDTH-1:0] dec_instr_o;
  logic [ADDR_WIDTH-1:0] dec_addr_o;

  modport master (
    input  jmp_valid_i, jmp_addr_i, mem_rdata_i, dec_ready_i,
    output mem_en_o, mem_addr_o, dec_valid_o, dec_instr_o, dec_addr_o
  );

  modport slave (
    output jmp_valid_i, jmp_addr_i, mem_rdata_i, dec_ready_i,
    input  mem_en_o, mem_addr_o, dec_valid_o, dec_instr_o, dec_addr_o
  );
endinterface

// File: rtl/jedro_1_ifu_prefetch_fifo.sv
// jedro_1_fifo: synchronous FIFO with flush, used as the prefetch buffer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   flush_i      : drop all entries at the next edge (wins over push/pop)
//   push_i/wdata_i, pop_i/rdata_o : write side, read side (rdata_o = head)
//   full_o, empty_o, count_o      : occupancy status
module jedro_1_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // A push into a full FIFO is accepted only when the head leaves this cycle.
  assign w_push  = push_i && (!full_o || pop_i);
  assign w_pop   = pop_i && !empty_o;

  assign full_o  = (r_count == CW'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign rdata_o = r_mem[r_rptr];

  // Storage carries no reset; stale words are never visible because
  // occupancy comes only from r_count.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/jedro_1_ifu_prefetch.sv
// jedro_1_ifu_prefetch: instruction fetch stage of the jedro_1 core.
// Streams sequential word reads from a one-cycle-latency ROM into a small
// prefetch FIFO and presents the head to the decoder with valid/ready.
// A redirect flushes the FIFO and drops the response still in flight.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (master) : jmp_valid_i/jmp_addr_i redirect, mem_en_o/mem_addr_o/
//                  mem_rdata_i ROM port, dec_valid_o/dec_ready_i/
//                  dec_instr_o/dec_addr_o decoder handshake
// fetch_entry_t fixes both fields at XLEN, matching the default widths.
module jedro_1_ifu_prefetch
  import jedro_1_defines::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter int                  DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = 32'h0000_0000
) (
  input logic                     clk_i,
  input logic                     rst_i,
  jedro_1_ifu_prefetch_if.master  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] r_req_addr;
  logic                  r_inflight;

  logic [CW-1:0]         w_count;
  logic                  w_full;
  logic                  w_empty;
  logic [CW:0]           w_occ;
  logic                  w_issue;
  logic                  w_pop;
  fetch_entry_t          w_wentry;
  fetch_entry_t          w_head;

  // Slots already committed = buffered + the one response still on its way.
  // Issuing only while this is below DEPTH is what keeps the FIFO from
  // overflowing, so no full check is needed on the push side.
  assign w_occ   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue = !rst_i && !bus.jmp_valid_i && (w_occ < (CW+1)'(DEPTH));

  assign bus.mem_en_o   = w_issue;
  assign bus.mem_addr_o = r_pc;

  assign bus.dec_valid_o = !rst_i && !w_empty;
  assign bus.dec_instr_o = bus.dec_valid_o ? w_head.instr : '0;
  assign bus.dec_addr_o  = bus.dec_valid_o ? w_head.addr  : '0;
  assign w_pop           = bus.dec_valid_o && bus.dec_ready_i;

  assign w_wentry = '{instr: bus.mem_rdata_i, addr: r_req_addr};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pc       <= BOOT_ADDR;
      r_req_addr <= '0;
      r_inflight <= 1'b0;
    end else if (bus.jmp_valid_i) begin
      // Clearing r_inflight drops the word the ROM returns next cycle.
      r_pc       <= align_word(bus.jmp_addr_i);
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_addr <= r_pc;
        r_pc       <= r_pc + ADDR_WIDTH'(INSTR_BYTES);
      end
    end
  end

  // Flush on redirect takes priority over the same-cycle push and pop.
  jedro_1_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .flush_i (bus.jmp_valid_i),
    .push_i  (r_inflight),
    .wdata_i (w_wentry),
    .pop_i   (w_pop),
    .rdata_o (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  a_count_le_depth : assert property (@(posedge clk_i) disable iff (rst_i)
    w_count <= CW'(DEPTH));

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_full && r_inflight && !w_pop && !bus.jmp_valid_i));

endmodule

// File: tb/tb_jedro_1_ifu_prefetch.sv
module tb_jedro_1_ifu_prefetch;
  import jedro_1_defines::*;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BOOT  = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  jedro_1_ifu_prefetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bif();

  jedro_1_ifu_prefetch #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .BOOT_ADDR  (BOOT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif)
  );

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0413;
    if (a == 32'h4) return 32'h0060_0493;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
  endfunction

  // Synchronous-read ROM model
  always_ff @(posedge clk) begin
    if (bif.mem_en_o) bif.mem_rdata_i <= rom_f(bif.mem_addr_o);
  end

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  logic [31:0] exp_pc = BOOT;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every issued fetch is queued with its issue cycle; the queue
  // length is the committed occupancy and the head becomes visible two
  // cycles after issue.
  task automatic monitor();
    logic exp_en, exp_vld;
    exp_t e;
    exp_en  = !rst && !bif.jmp_valid_i && (sb.size() < DEPTH);
    exp_vld = !rst && (sb.size() > 0) && ((cyc - sb[0].cyc) >= 2);
    chk("mem_en", bif.mem_en_o, exp_en);
    chk("dec_valid", bif.dec_valid_o, exp_vld);
    if (bif.dec_valid_o && bif.dec_ready_i && exp_vld) begin
      e = sb.pop_front();
      chk("dec_addr", bif.dec_addr_o, e.addr);
      chk("dec_instr", bif.dec_instr_o, e.instr);
    end
    if (bif.mem_en_o && exp_en) begin
      chk("mem_addr", bif.mem_addr_o, exp_pc);
      sb.push_back('{rom_f(exp_pc), exp_pc, cyc});
      exp_pc += 32'd4;
    end
    if (rst) begin
      sb.delete();
      exp_pc = BOOT;
    end else if (bif.jmp_valid_i) begin
      sb.delete();
      exp_pc = {bif.jmp_addr_i[31:2], 2'b00};
    end
    cyc++;
  endtask

  task automatic drive(input logic r, input logic jv, input logic [31:0] ja, input logic rdy);
    rst             = r;
    bif.jmp_valid_i = jv;
    bif.jmp_addr_i  = ja;
    bif.dec_ready_i = rdy;
  endtask

  task automatic cycle();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic rdy);
    drive(1'b0, 1'b0, 32'h0, rdy);
    for (int i = 0; i < n; i++) cycle();
  endtask

  typedef struct {
    logic        r;
    logic        rdy;
    logic        e_en;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_daddr;
    logic [31:0] e_instr;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 32'h0,  1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0,  1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h4,  1'b0, 32'h0, 32'h0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h8,  1'b1, 32'h0, 32'h0050_0413};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'hC,  1'b1, 32'h4, 32'h0060_0493};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, rom_f(32'h8)};

    drive(1'b1, 1'b0, 32'h0, 1'b0);
    cycle();
    cycle();

    // Reset release and first deliveries
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i].r, 1'b0, 32'h0, tbl[i].rdy);
      @(negedge clk);
      chk($sformatf("tbl%0d_mem_en", i),    bif.mem_en_o,    tbl[i].e_en);
      chk($sformatf("tbl%0d_mem_addr", i),  bif.mem_addr_o,  tbl[i].e_addr);
      chk($sformatf("tbl%0d_dec_valid", i), bif.dec_valid_o, tbl[i].e_vld);
      chk($sformatf("tbl%0d_dec_addr", i),  bif.dec_addr_o,  tbl[i].e_daddr);
      chk($sformatf("tbl%0d_dec_instr", i), bif.dec_instr_o, tbl[i].e_instr);
      monitor();
      @(posedge clk);
      #1;
    end
    run(4, 1'b1);

    // Decoder stall fills exactly DEPTH entries, then drains in order
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    cycle();
    run(10, 1'b0);
    chk("stall_count", dut.w_count, 64'(DEPTH));
    chk("stall_mem_en", bif.mem_en_o, 1'b0);
    run(10, 1'b1);

    // Redirect with 3 buffered entries and one response in flight
    drive(1'b1, 1'b0, 32'h0, 1'b0);
    cycle();
    run(4, 1'b0);
    chk("pre_jmp_count", dut.w_count, 64'd3);
    chk("pre_jmp_inflight", dut.r_inflight, 1'b1);
    drive(1'b0, 1'b1, 32'h40, 1'b0);
    cycle();
    chk("post_jmp_count", dut.w_count, 64'd0);
    chk("post_jmp_addr", bif.mem_addr_o, 32'h40);
    run(6, 1'b1);

    // Unaligned redirect coinciding with a pop
    chk("pre_jmp43_valid", bif.dec_valid_o, 1'b1);
    drive(1'b0, 1'b1, 32'h43, 1'b1);
    cycle();
    run(6, 1'b1);

    // Back-to-back redirects: last one wins
    drive(1'b0, 1'b1, 32'h100, 1'b1);
    cycle();
    drive(1'b0, 1'b1, 32'h20A, 1'b1);
    cycle();
    run(6, 1'b1);

    // One-cycle reset with the FIFO full
    run(6, 1'b0);
    chk("full_before_rst", dut.w_count, 64'(DEPTH));
    drive(1'b1, 1'b0, 32'h0, 1'b1);
    #1;
    chk("rst_dec_valid", bif.dec_valid_o, 1'b0);
    chk("rst_mem_en", bif.mem_en_o, 1'b0);
    cycle();
    chk("rst_restart_addr", bif.mem_addr_o, BOOT);
    run(8, 1'b1);

    // Fetch PC wrap-around
    drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle();
    run(8, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
